// File: rtl/control_sequencer.sv
// Multicycle ARM-style control sequencer: registered state, combinational next state,
// memory-wait timeout with abort, and registered instruction-boundary pulses.
module control_sequencer #(
   parameter int STATE_W     = 7,
   parameter int IR_W        = 32,
   parameter int MOC_TIMEOUT = 15,
   parameter int CNT_W       = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               moc,
   input  logic               cond,
   input  logic [IR_W-1:0]    ir,
   output logic [STATE_W-1:0] state,
   output logic [STATE_W-1:0] next_state,
   output logic               fetch_done,
   output logic               instr_done,
   output logic               mem_abort
);

   typedef enum logic [STATE_W-1:0] {
      S_IDLE      = STATE_W'(0),
      S_FETCH1    = STATE_W'(1),
      S_FETCH2    = STATE_W'(2),
      S_IWAIT     = STATE_W'(3),
      S_DECODE    = STATE_W'(4),
      S_DP_REG    = STATE_W'(5),
      S_DP_IMM    = STATE_W'(6),
      S_BRANCH    = STATE_W'(7),
      S_LINK      = STATE_W'(8),
      S_ADDR_IU   = STATE_W'(33),
      S_LDREQ     = STATE_W'(34),
      S_MWAIT     = STATE_W'(35),
      S_XFER      = STATE_W'(36),
      S_ADDR_RD   = STATE_W'(37),
      S_WB_UP     = STATE_W'(39),
      S_ADDR_POST = STATE_W'(40),
      S_STREQ     = STATE_W'(44),
      S_ADDR_ID   = STATE_W'(46),
      S_ADDR_RU   = STATE_W'(47),
      S_WB_DN     = STATE_W'(49),
      S_ABORT     = STATE_W'(62)
   } state_t;

   localparam logic [STATE_W-1:0] C_LAST_INSTR = STATE_W'(61);
   localparam logic [CNT_W-1:0]   C_LIMIT      = CNT_W'((MOC_TIMEOUT > 0) ? MOC_TIMEOUT - 1 : 0);
   localparam logic               C_TO_EN      = (MOC_TIMEOUT > 0);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             r_fetch_done;
   logic             r_instr_done;
   logic             r_mem_abort;
   logic             w_wait;
   logic             w_timeout;
   logic             w_retire;
   logic             w_unused_ir;

   // Decode field D = ir[27:25] plus P/U bits select the first execute state.
   function automatic state_t f_decode(input logic [IR_W-1:0] i_ir);
      state_t v_s;
      v_s = S_IDLE;
      case (i_ir[27:25])
         3'b000:  v_s = S_DP_REG;
         3'b001:  v_s = S_DP_IMM;
         3'b101:  v_s = i_ir[24] ? S_LINK : S_BRANCH;
         3'b010: begin
            if (!i_ir[24]) v_s = S_ADDR_POST;
            else           v_s = i_ir[23] ? S_ADDR_IU : S_ADDR_ID;
         end
         3'b011: begin
            if (!i_ir[24]) v_s = S_ADDR_POST;
            else           v_s = i_ir[23] ? S_ADDR_RU : S_ADDR_RD;
         end
         default: v_s = S_IDLE;
      endcase
      return v_s;
   endfunction

   // Post-indexed transfers always write back; pre-indexed only when W is set.
   function automatic state_t f_after_xfer(input logic [IR_W-1:0] i_ir);
      state_t v_s;
      v_s = S_IDLE;
      if (!i_ir[24] || i_ir[21]) v_s = i_ir[23] ? S_WB_UP : S_WB_DN;
      return v_s;
   endfunction

   assign w_unused_ir = ^ir;
   assign w_wait      = ((r_state == S_IWAIT) || (r_state == S_MWAIT)) && !moc;
   assign w_timeout   = C_TO_EN && w_wait && (r_cnt == C_LIMIT);

   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE:      w_next = S_FETCH1;
         S_FETCH1:    w_next = S_FETCH2;
         S_FETCH2:    w_next = S_IWAIT;
         S_IWAIT:     w_next = moc ? S_DECODE : S_IWAIT;
         S_DECODE:    w_next = cond ? f_decode(ir) : S_IDLE;
         S_DP_REG,
         S_DP_IMM:    w_next = S_IDLE;
         S_LINK:      w_next = S_BRANCH;
         S_BRANCH:    w_next = S_IDLE;
         S_ADDR_IU,
         S_ADDR_ID,
         S_ADDR_RU,
         S_ADDR_RD,
         S_ADDR_POST: w_next = ir[20] ? S_LDREQ : S_STREQ;
         S_LDREQ,
         S_STREQ:     w_next = S_MWAIT;
         S_MWAIT:     w_next = moc ? S_XFER : S_MWAIT;
         S_XFER:      w_next = f_after_xfer(ir);
         S_WB_UP,
         S_WB_DN:     w_next = S_IDLE;
         S_ABORT:     w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
      // moc has already won inside w_wait, so a timeout only overrides a self-loop.
      if (w_timeout) w_next = S_ABORT;
   end

   assign w_retire = (w_next == S_IDLE) && (r_state >= S_DECODE) && (r_state <= C_LAST_INSTR);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_fetch_done <= 1'b0;
         r_instr_done <= 1'b0;
         r_mem_abort  <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_cnt        <= (C_TO_EN && w_wait) ? r_cnt + CNT_W'(1) : '0;
         r_fetch_done <= (r_state == S_IWAIT) && (w_next == S_DECODE);
         r_instr_done <= w_retire;
         r_mem_abort  <= (w_next == S_ABORT) && (r_state != S_ABORT);
      end
   end

   assign state      = r_state;
   assign next_state = w_next;
   assign fetch_done = r_fetch_done;
   assign instr_done = r_instr_done;
   assign mem_abort  = r_mem_abort;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a per-instruction path model builds the
// expected state trace, a negedge monitor compares every cycle.
module tb_control_sequencer;

   localparam int T = 15;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        moc = 1'b0;
   logic        cond = 1'b0;
   logic [31:0] ir = '0;
   logic [6:0]  state;
   logic [6:0]  next_state;
   logic        fetch_done;
   logic        instr_done;
   logic        mem_abort;

   control_sequencer #(.STATE_W(7), .IR_W(32), .MOC_TIMEOUT(T), .CNT_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .moc(moc), .cond(cond), .ir(ir),
      .state(state), .next_state(next_state),
      .fetch_done(fetch_done), .instr_done(instr_done), .mem_abort(mem_abort)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] st;
      logic [6:0] nx;
      logic       fd;
      logic       id;
      logic       ma;
   } exp_t;

   exp_t sb[$];
   int   q_st[$];
   logic q_moc[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   prev    = 0;
   bit   mon_en  = 0;
   bit   aborted;

   always @(negedge clk) begin
      if (mon_en) begin
         cyc++;
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty cyc=%0d state=%0d", cyc, state);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if ({state, next_state, fetch_done, instr_done, mem_abort} !==
                {e.st, e.nx, e.fd, e.id, e.ma}) begin
               n_fail++;
               $display("FAIL trace cyc=%0d got st=%0d nx=%0d fd=%0b id=%0b ma=%0b want st=%0d nx=%0d fd=%0b id=%0b ma=%0b",
                        cyc, state, next_state, fetch_done, instr_done, mem_abort,
                        e.st, e.nx, e.fd, e.id, e.ma);
            end
         end
      end
   end

   task automatic check(input string name, input int got, input int want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   task automatic add(input int s, input logic m);
      q_st.push_back(s);
      q_moc.push_back(m);
   endtask

   // k cycles without moc; the limit T turns a long wait into an abort.
   task automatic add_wait(input int code, input int k);
      if (k >= T) begin
         for (int i = 0; i < T; i++) add(code, 1'b0);
         add(62, 1'($urandom));
         aborted = 1;
      end else begin
         for (int i = 0; i < k; i++) add(code, 1'b0);
         add(code, 1'b1);
      end
   endtask

   task automatic build(input logic [31:0] iv, input logic cv, input int kf, input int km);
      logic [2:0] d;
      int a;
      q_st.delete();
      q_moc.delete();
      aborted = 0;
      d = iv[27:25];
      add(0, 1'($urandom));
      add(1, 1'($urandom));
      add(2, 1'($urandom));
      add_wait(3, kf);
      if (aborted) return;
      add(4, 1'($urandom));
      if (!cv) return;
      if (d == 3'd0) add(5, 1'($urandom));
      else if (d == 3'd1) add(6, 1'($urandom));
      else if (d == 3'd5) begin
         if (iv[24]) add(8, 1'($urandom));
         add(7, 1'($urandom));
      end else if (d == 3'd2 || d == 3'd3) begin
         if (!iv[24]) a = 40;
         else if (d == 3'd2) a = iv[23] ? 33 : 46;
         else a = iv[23] ? 47 : 37;
         add(a, 1'($urandom));
         add(iv[20] ? 34 : 44, 1'($urandom));
         add_wait(35, km);
         if (aborted) return;
         add(36, 1'($urandom));
         if (!iv[24] || iv[21]) add(iv[23] ? 39 : 49, 1'($urandom));
      end
   endtask

   task automatic play();
      for (int i = 0; i < q_st.size(); i++) begin
         exp_t e;
         e.st = 7'(q_st[i]);
         e.nx = (i + 1 < q_st.size()) ? 7'(q_st[i+1]) : 7'd0;
         e.fd = (q_st[i] == 4) && (prev == 3);
         e.id = (q_st[i] == 0) && (prev >= 4) && (prev <= 61);
         e.ma = (q_st[i] == 62);
         prev = q_st[i];
         moc  = q_moc[i];
         sb.push_back(e);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_instr(input logic [31:0] iv, input logic cv, input int kf, input int km);
      ir   = iv;
      cond = cv;
      build(iv, cv, kf, km);
      play();
   endtask

   initial begin
      int r;
      int kf;
      int km;
      bit seen;

      #3;
      check("rst_state", state, 0);
      check("rst_pulses", {fetch_done, instr_done, mem_abort}, 0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold_state", state, 0);
      check("rst_hold_pulses", {fetch_done, instr_done, mem_abort}, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      prev    = 0;
      mon_en  = 1;

      run_instr(32'hE3A01005, 1'b1, 2, 0);
      run_instr(32'hEB000010, 1'b1, 0, 0);
      run_instr(32'hEB000010, 1'b0, 1, 0);
      run_instr(32'hE5B21004, 1'b1, 0, 1);
      run_instr(32'hE4021004, 1'b1, 1, 3);
      run_instr(32'hE7921003, 1'b1, 0, 0);
      run_instr(32'hE5B21004, 1'b1, 0, 15);
      run_instr(32'hE5B21004, 1'b1, 0, 14);
      run_instr(32'hEC000000, 1'b1, 0, 0);
      run_instr(32'hE3A01005, 1'b1, 15, 0);
      run_instr(32'hE3A01005, 1'b1, 14, 0);
      run_instr(32'hE4021004, 1'b1, 0, 20);

      for (int n = 0; n < 150; n++) begin
         r  = $urandom_range(0, 9);
         kf = (r == 0) ? $urandom_range(13, 17) : $urandom_range(0, 3);
         r  = $urandom_range(0, 5);
         km = (r == 0) ? $urandom_range(13, 17) : $urandom_range(0, 4);
         run_instr($urandom, ($urandom_range(0, 7) != 0), kf, km);
      end

      // Asynchronous reset while parked in the memory wait state.
      mon_en = 0;
      ir     = 32'hE5B21004;
      cond   = 1'b1;
      seen   = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         moc = (state == 7'd3);
         @(posedge clk);
         #1;
         if (state == 7'd35) seen = 1;
      end
      check("reach_mwait", int'(seen), 1);
      moc = 1'b0;
      repeat (6) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check("async_rst_state", state, 0);
      check("async_rst_pulses", {fetch_done, instr_done, mem_abort}, 0);
      check("async_rst_next", next_state, 1);
      @(posedge clk);
      #1;
      check("async_rst_held", state, 0);
      reset_n = 1'b1;
      prev    = 0;
      mon_en  = 1;
      run_instr(32'hE5B21004, 1'b1, 0, 14);
      run_instr(32'hE4021004, 1'b1, 14, 15);
      mon_en = 0;

      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
